// File: rtl/wb_rr_arbiter_pkg.sv
// Shared constants for the Wishbone N-master arbiter: default bus widths,
// FSM state encoding and the watchdog counter width.
package wb_rr_arbiter_pkg;

  localparam int unsigned WB_ADDR_W   = 24;
  localparam int unsigned WB_DATA_W   = 16;
  localparam int unsigned WB_SEL_BITS = 2;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

  localparam int unsigned TMO_CNT_W = 16;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of per-master Wishbone signals plus the shared slave bus.
// The slave modport is the arbiter's view; the master modport is the view
// of everything around it (masters and the slave device).
interface wb_rr_arbiter_if
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned DATA_W    = WB_DATA_W,
  parameter int unsigned ADDR_W    = WB_ADDR_W,
  parameter int unsigned SEL_W     = WB_SEL_BITS
);

  logic [N_MASTERS-1:0]        m_cyc;
  logic [N_MASTERS-1:0]        m_stb;
  logic [N_MASTERS-1:0]        m_we;
  logic [N_MASTERS*ADDR_W-1:0] m_adr;
  logic [N_MASTERS*DATA_W-1:0] m_dat_o;
  logic [N_MASTERS*SEL_W-1:0]  m_sel;
  logic [N_MASTERS-1:0]        m_4_burst;
  logic [N_MASTERS-1:0]        m_8_burst;
  logic [N_MASTERS-1:0]        m_ack;
  logic [N_MASTERS-1:0]        m_err;
  logic [N_MASTERS-1:0]        m_rty;

  logic                        wb_cyc;
  logic                        wb_stb;
  logic                        wb_we;
  logic [ADDR_W-1:0]           wb_adr;
  logic [DATA_W-1:0]           wb_o_dat;
  logic [SEL_W-1:0]            wb_sel;
  logic                        wb_4_burst;
  logic                        wb_8_burst;
  logic                        wb_ack;
  logic                        wb_err;
  logic                        wb_rty;

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_o, m_sel, m_4_burst, m_8_burst,
    input  wb_ack, wb_err, wb_rty,
    output m_ack, m_err, m_rty,
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel, wb_4_burst, wb_8_burst
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_o, m_sel, m_4_burst, m_8_burst,
    output wb_ack, wb_err, wb_rty,
    input  m_ack, m_err, m_rty,
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel, wb_4_burst, wb_8_burst
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational first-set-bit search over a request vector, starting at a
// rotating base index and wrapping past the top index back to 0.
module wb_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] base_i,
  output logic             found_c_o,
  output logic [IDX_W-1:0] idx_c_o
);

  int pos;

  // Scan N positions from base, first requester wins
  always_comb begin
    found_c_o = 1'b0;
    idx_c_o   = '0;
    pos       = 0;
    for (int i = 0; i < int'(N); i++) begin
      pos = int'(base_i) + i;
      if (pos >= int'(N)) pos = pos - int'(N);
      if (!found_c_o && req_i[IDX_W'(pos)]) begin
        found_c_o = 1'b1;
        idx_c_o   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master Wishbone arbiter and bus mux with fixed-priority or round-robin
// winner selection. The grant is held for the owner's whole cycle; request
// signals are routed from the owner's slice and responses return only to it.
// Optional build macro WB_ARB_TIMEOUT_EN adds a strobe watchdog that errors
// out a stalled owner after TIMEOUT_CYCLES unanswered strobe cycles.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned DATA_W    = WB_DATA_W,
  parameter int unsigned ADDR_W    = WB_ADDR_W,
  parameter int unsigned SEL_W     = WB_SEL_BITS,
`ifdef WB_ARB_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
  localparam int unsigned IDX_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rr_mode,
  wb_rr_arbiter_if.slave       bus,
  output logic [N_MASTERS-1:0] o_grant,
  output logic [IDX_W-1:0]     o_sel_idx
);

  logic [0:0]           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     base_c;
  logic                 pick_found_c;
  logic [IDX_W-1:0]     pick_idx_c;
  logic                 tmo_hit_c;

  // Round-robin starts just after the last winner; fixed priority from 0
  assign base_c = !i_rr_mode ? '0 :
                  (last_q == IDX_W'(N_MASTERS - 1)) ? '0 : last_q + 1'b1;

  wb_rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (bus.m_cyc),
    .base_i    (base_c),
    .found_c_o (pick_found_c),
    .idx_c_o   (pick_idx_c)
  );

  // Arbitration FSM: issue grant from IDLE, release when owner drops cyc
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found_c) begin
          state_d = ARB_BUSY;
          grant_d = N_MASTERS'(1) << pick_idx_c;
          sel_d   = pick_idx_c;
          last_d  = pick_idx_c;
        end
      end
      ARB_BUSY: begin
        if (!bus.m_cyc[sel_q]) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= IDX_W'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 resp_c;

  assign resp_c    = bus.wb_ack | bus.wb_err | bus.wb_rty;
  assign tmo_hit_c = (state_q == ARB_BUSY) && bus.m_stb[sel_q] &&
                     (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES));

  // Watchdog: count unanswered strobe cycles, clear on grant/response/expiry
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ARB_IDLE || resp_c || tmo_hit_c) begin
      tmo_cnt_d = '0;
    end else if (bus.m_stb[sel_q]) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Bus mux from the owner's slice; responses steered back to the owner only
  always_comb begin
    bus.wb_cyc     = 1'b0;
    bus.wb_stb     = 1'b0;
    bus.wb_we      = 1'b0;
    bus.wb_adr     = '0;
    bus.wb_o_dat   = '0;
    bus.wb_sel     = '0;
    bus.wb_4_burst = 1'b0;
    bus.wb_8_burst = 1'b0;
    bus.m_ack      = '0;
    bus.m_err      = '0;
    bus.m_rty      = '0;
    if (state_q == ARB_BUSY) begin
      bus.wb_cyc     = bus.m_cyc[sel_q];
      bus.wb_stb     = bus.m_stb[sel_q] & ~tmo_hit_c;
      bus.wb_we      = bus.m_we[sel_q];
      bus.wb_adr     = bus.m_adr[int'(sel_q) * ADDR_W +: ADDR_W];
      bus.wb_o_dat   = bus.m_dat_o[int'(sel_q) * DATA_W +: DATA_W];
      bus.wb_sel     = bus.m_sel[int'(sel_q) * SEL_W +: SEL_W];
      bus.wb_4_burst = bus.m_4_burst[sel_q];
      bus.wb_8_burst = bus.m_8_burst[sel_q];
      bus.m_ack[sel_q] = bus.wb_ack;
      bus.m_err[sel_q] = bus.wb_err | tmo_hit_c;
      bus.m_rty[sel_q] = bus.wb_rty;
    end
  end

  assign o_grant   = grant_q;
  assign o_sel_idx = sel_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: reset, fixed priority, round-robin
// rotation, no-preemption bursts, response isolation and async reset.
module tb_wb_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 24;
  localparam int unsigned SW = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         rr_mode;
  logic [N-1:0] grant;
  logic [1:0]   sel_idx;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.N_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .SEL_W(SW)) bus ();

  wb_rr_arbiter #(
    .N_MASTERS (N),
    .DATA_W    (DW),
    .ADDR_W    (AW),
`ifdef WB_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES (8),
`endif
    .SEL_W     (SW)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rr_mode (rr_mode),
    .bus       (bus),
    .o_grant   (grant),
    .o_sel_idx (sel_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] adr_of(input int k);
    return 24'hA00000 + 24'(k) * 24'h001111;
  endfunction

  function automatic logic [DW-1:0] dat_of(input int k);
    return 16'hD000 + 16'(k);
  endfunction

  function automatic logic [SW-1:0] sel_of(input int k);
    return SW'(k + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_seq [5];
  logic [1:0] e;

  initial begin
    rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2;
    rr_seq[3] = 2'd3; rr_seq[4] = 2'd0;
    rst = 1'b0;
    rr_mode = 1'b0;
    bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0;
    bus.m_4_burst = '0; bus.m_8_burst = '0;
    bus.wb_ack = 1'b0; bus.wb_err = 1'b0; bus.wb_rty = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      bus.m_adr[k*AW +: AW]   = adr_of(k);
      bus.m_dat_o[k*DW +: DW] = dat_of(k);
      bus.m_sel[k*SW +: SW]   = sel_of(k);
    end
    #1;
    chk("reset_grant", 64'(grant), 64'(4'b0000));
    chk("reset_sel_idx", 64'(sel_idx), 64'(2'd0));
    chk("reset_wb_cyc", 64'(bus.wb_cyc), 64'(1'b0));
    step(); step();
    rst = 1'b1;
    step();

    // Response isolation with master 1 as owner
    bus.m_cyc = 4'b0010; bus.m_stb = 4'b0010;
    #1;
    chk("iso_latency", 64'(grant), 64'(4'b0000));
    step();
    chk("iso_grant", 64'(grant), 64'(4'b0010));
    chk("iso_sel_idx", 64'(sel_idx), 64'(2'd1));
    chk("iso_wb_cyc", 64'(bus.wb_cyc), 64'(1'b1));
    chk("iso_wb_adr", 64'(bus.wb_adr), 64'(24'hA01111));
    chk("iso_wb_dat", 64'(bus.wb_o_dat), 64'(16'hD001));
    chk("iso_wb_sel", 64'(bus.wb_sel), 64'(2'b10));
    bus.wb_err = 1'b1;
    #1;
    chk("iso_m_err", 64'(bus.m_err), 64'(4'b0010));
    chk("iso_m_ack", 64'(bus.m_ack), 64'(4'b0000));
    chk("iso_m_rty", 64'(bus.m_rty), 64'(4'b0000));
    bus.wb_err = 1'b0; bus.wb_rty = 1'b1;
    #1;
    chk("iso_m_rty2", 64'(bus.m_rty), 64'(4'b0010));
    chk("iso_m_err2", 64'(bus.m_err), 64'(4'b0000));
    bus.wb_rty = 1'b0; bus.m_cyc = '0; bus.m_stb = '0;
    step();
    chk("iso_release", 64'(grant), 64'(4'b0000));

    // Fixed priority: masters 1 and 3 request, 1 wins, then 3 after a dead cycle
    bus.m_cyc = 4'b1010; bus.m_stb = 4'b1010; bus.m_we = 4'b1010;
    step();
    chk("fp_grant1", 64'(grant), 64'(4'b0010));
    chk("fp_adr1", 64'(bus.wb_adr), 64'(24'hA01111));
    chk("fp_we1", 64'(bus.wb_we), 64'(1'b1));
    bus.wb_ack = 1'b1;
    #1;
    chk("fp_ack1", 64'(bus.m_ack), 64'(4'b0010));
    step();
    bus.wb_ack = 1'b0; bus.m_cyc = 4'b1000; bus.m_stb = 4'b1000;
    #1;
    chk("fp_drop_wb_cyc", 64'(bus.wb_cyc), 64'(1'b0));
    step();
    chk("fp_dead_grant", 64'(grant), 64'(4'b0000));
    chk("fp_dead_adr", 64'(bus.wb_adr), 64'(24'h000000));
    chk("fp_dead_sel_idx", 64'(sel_idx), 64'(2'd1));
    step();
    chk("fp_grant3", 64'(grant), 64'(4'b1000));
    chk("fp_sel_idx3", 64'(sel_idx), 64'(2'd3));
    chk("fp_adr3", 64'(bus.wb_adr), 64'(24'hA03333));
    chk("fp_dat3", 64'(bus.wb_o_dat), 64'(16'hD003));
    bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0;
    step();
    chk("fp_idle", 64'(grant), 64'(4'b0000));

    // Round-robin: all masters request, each releases for one cycle per turn
    rr_mode = 1'b1;
    bus.m_cyc = 4'b1111; bus.m_stb = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      e = rr_seq[t];
      step();
      chk("rr_grant", 64'(grant), 64'(4'(4'b0001 << e)));
      bus.wb_ack = 1'b1;
      #1;
      chk("rr_ack", 64'(bus.m_ack), 64'(4'(4'b0001 << e)));
      step();
      bus.wb_ack = 1'b0; bus.m_cyc[e] = 1'b0; bus.m_stb[e] = 1'b0;
      #1;
      chk("rr_drop_wb_cyc", 64'(bus.wb_cyc), 64'(1'b0));
      step();
      chk("rr_dead_grant", 64'(grant), 64'(4'b0000));
      bus.m_cyc[e] = 1'b1; bus.m_stb[e] = 1'b1;
    end
    bus.m_cyc = '0; bus.m_stb = '0;
    step();
    chk("rr_idle", 64'(grant), 64'(4'b0000));

    // No preemption: master 3 bursts 8 beats while master 0 waits
    rr_mode = 1'b0;
    bus.m_cyc = 4'b1000; bus.m_stb = 4'b1000; bus.m_8_burst = 4'b1000;
    step();
    chk("np_grant3", 64'(grant), 64'(4'b1000));
    bus.m_cyc = 4'b1001; bus.m_stb = 4'b1001;
    for (int b = 0; b < 8; b++) begin
      bus.wb_ack = 1'b1;
      #1;
      chk("np_hold", 64'(grant), 64'(4'b1000));
      chk("np_burst8", 64'(bus.wb_8_burst), 64'(1'b1));
      chk("np_ack", 64'(bus.m_ack), 64'(4'b1000));
      step();
    end
    bus.wb_ack = 1'b0; bus.m_cyc = 4'b0001; bus.m_stb = 4'b0001; bus.m_8_burst = '0;
    step();
    chk("np_dead", 64'(grant), 64'(4'b0000));
    step();
    chk("np_grant0", 64'(grant), 64'(4'b0001));
    chk("np_sel_idx0", 64'(sel_idx), 64'(2'd0));
    bus.m_cyc = '0; bus.m_stb = '0;
    step();

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: slave never answers, error pulses once after 8 strobe cycles
    bus.m_cyc = 4'b0001; bus.m_stb = 4'b0001;
    step();
    chk("tmo_grant", 64'(grant), 64'(4'b0001));
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 8) begin
        chk("tmo_err_pulse", 64'(bus.m_err), 64'(4'b0001));
        chk("tmo_stb_forced", 64'(bus.wb_stb), 64'(1'b0));
      end else begin
        chk("tmo_err_quiet", 64'(bus.m_err), 64'(4'b0000));
        chk("tmo_stb_live", 64'(bus.wb_stb), 64'(1'b1));
      end
    end
    chk("tmo_grant_held", 64'(grant), 64'(4'b0001));
    bus.m_cyc = '0; bus.m_stb = '0;
    step();
`endif

    // Asynchronous reset while master 2 owns the bus with a live strobe
    bus.m_cyc = 4'b0100; bus.m_stb = 4'b0100;
    step();
    chk("rst_pre_grant", 64'(grant), 64'(4'b0100));
    chk("rst_pre_stb", 64'(bus.wb_stb), 64'(1'b1));
    bus.wb_ack = 1'b1;
    #1;
    chk("rst_pre_ack", 64'(bus.m_ack), 64'(4'b0100));
    #2;
    rst = 1'b0;
    #1;
    chk("rst_grant", 64'(grant), 64'(4'b0000));
    chk("rst_wb_cyc", 64'(bus.wb_cyc), 64'(1'b0));
    chk("rst_wb_stb", 64'(bus.wb_stb), 64'(1'b0));
    chk("rst_m_ack", 64'(bus.m_ack), 64'(4'b0000));
    chk("rst_sel_idx", 64'(sel_idx), 64'(2'd0));
    bus.wb_ack = 1'b0; bus.m_cyc = '0; bus.m_stb = '0;
    step();
    rst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
